// File: rtl/lu_pkg.sv
// rtl/lu_pkg.sv - shared opcodes and widths for the logic-unit arbiter
package lu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  localparam int LU_W   = 8;
  localparam int PERF_W = 16;

endpackage

// File: rtl/lu_core.sv
// rtl/lu_core.sv - combinational bitwise logic unit (AND/OR/XOR/NOT)
module lu_core
  import lu_pkg::*;
#(
  parameter int W = LU_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/lu_arbiter.sv
// rtl/lu_arbiter.sv - round-robin share of one logic unit; LU_ARBITER_PERF_EN adds per-requester grant counters
module lu_arbiter
  import lu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = LU_W,
  localparam int IDW = (NREQ <= 2) ? 1 : $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*2-1:0] req_op,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [W-1:0]      resp_y,
  output logic [IDW-1:0]    resp_id
`ifdef LU_ARBITER_PERF_EN
  ,
  input  logic [IDW-1:0]    perf_sel,
  output logic [PERF_W-1:0] perf_cnt
`endif
);

  logic           resp_valid_q, resp_valid_d;
  logic [W-1:0]   resp_y_q, resp_y_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic           found;
  logic [IDW-1:0] gnt;
  logic           can_issue;
  logic           issue;
  logic [W-1:0]   lu_y;

  // First valid requester at or after ptr, wrapping.
  always_comb begin
    int idx;
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = IDW'(idx);
      end
    end
  end

  assign can_issue = !resp_valid_q || resp_ready;
  assign issue     = found && can_issue;

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[gnt] = 1'b1;
  end

  lu_core #(.W(W)) u_lu_core (
    .a  (req_a[int'(gnt)*W +: W]),
    .b  (req_b[int'(gnt)*W +: W]),
    .op (req_op[int'(gnt)*2 +: 2]),
    .y  (lu_y)
  );

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_y_d     = resp_y_q;
    resp_id_d    = resp_id_q;
    ptr_d        = ptr_q;
    if (issue) begin
      resp_valid_d = 1'b1;
      resp_y_d     = lu_y;
      resp_id_d    = gnt;
      ptr_d        = (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_y_q     <= '0;
      resp_id_q    <= '0;
      ptr_q        <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_y_q     <= resp_y_d;
      resp_id_q    <= resp_id_d;
      ptr_q        <= ptr_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_y     = resp_y_q;
  assign resp_id    = resp_id_q;

`ifdef LU_ARBITER_PERF_EN
  logic [PERF_W-1:0] cnt_q [NREQ];
  logic [PERF_W-1:0] cnt_d [NREQ];

  // Counters saturate rather than wrap so a long run never reads as low.
  always_comb begin
    for (int i = 0; i < NREQ; i++) cnt_d[i] = cnt_q[i];
    if (issue && (cnt_q[gnt] != '1)) cnt_d[gnt] = cnt_q[gnt] + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign perf_cnt = (int'(perf_sel) < NREQ) ? cnt_q[perf_sel] : '0;
`endif

endmodule

// File: tb/tb_lu_arbiter.sv
// tb/tb_lu_arbiter.sv - randomized self-checking bench for lu_arbiter against a behavioural model
module tb_lu_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*2-1:0] req_op;
  logic              resp_valid;
  logic              resp_ready;
  logic [W-1:0]      resp_y;
  logic [IDW-1:0]    resp_id;
`ifdef LU_ARBITER_PERF_EN
  logic [IDW-1:0]    perf_sel;
  logic [15:0]       perf_cnt;
`endif

  always #5 clk = ~clk;

  lu_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_y     (resp_y),
    .resp_id    (resp_id)
`ifdef LU_ARBITER_PERF_EN
    ,
    .perf_sel   (perf_sel),
    .perf_cnt   (perf_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  bit         m_valid;
  logic [7:0] m_y;
  int         m_id;
  int         m_ptr;
  int         m_cnt [NREQ];

  function automatic logic [7:0] lu_ref(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_valid = 1'b0;
    m_y     = '0;
    m_id    = 0;
    m_ptr   = 0;
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
  endtask

  // Check current outputs against the model, take one edge, advance the model.
  task automatic cycle();
    int              g;
    int              bestd;
    bit              can;
    logic [NREQ-1:0] exp_ready;
    #1;
    can   = !m_valid || resp_ready;
    g     = -1;
    bestd = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i]) begin
        int d;
        d = (i - m_ptr + NREQ) % NREQ;
        if (d < bestd) begin
          bestd = d;
          g     = i;
        end
      end
    end
    exp_ready = '0;
    if (g >= 0 && can) exp_ready[g] = 1'b1;
    check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    check_eq("resp_valid", 32'(resp_valid), 32'(m_valid));
    if (m_valid) begin
      check_eq("resp_y", 32'(resp_y), 32'(m_y));
      check_eq("resp_id", 32'(resp_id), 32'(m_id));
    end
`ifdef LU_ARBITER_PERF_EN
    check_eq("perf_cnt", 32'(perf_cnt), 32'(m_cnt[perf_sel]));
`endif
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else if (g >= 0 && can) begin
      m_valid = 1'b1;
      m_y     = lu_ref(req_a[g*W +: W], req_b[g*W +: W], req_op[g*2 +: 2]);
      m_id    = g;
      m_ptr   = (g + 1) % NREQ;
      if (m_cnt[g] < 65535) m_cnt[g]++;
    end else if (resp_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_tbl [4];
    logic [7:0] held_y;
    exp_tbl[0] = 8'hC0;
    exp_tbl[1] = 8'hFC;
    exp_tbl[2] = 8'h3C;
    exp_tbl[3] = 8'h0F;

    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = 1'b1;
`ifdef LU_ARBITER_PERF_EN
    perf_sel   = '0;
`endif
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_y", 32'(resp_y), 32'd0);
    check_eq("rst_id", 32'(resp_id), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);

    // Requester 0 alone, all four opcodes back to back.
    req_valid   = 4'b0001;
    req_a[7:0]  = 8'hF0;
    req_b[7:0]  = 8'hCC;
    for (int k = 0; k < 4; k++) begin
      req_op[1:0] = 2'(k);
      cycle();
      check_eq("op_y", 32'(resp_y), 32'(exp_tbl[k]));
      check_eq("op_id", 32'(resp_id), 32'd0);
      check_eq("op_valid", 32'(resp_valid), 32'd1);
    end
    req_valid = '0;
    cycle();

    // All requesters continuously valid: strict rotation with no bubbles.
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      req_a  = {$urandom, $urandom};
      req_b  = {$urandom, $urandom};
      req_op = 8'($urandom);
      cycle();
      check_eq("rr_id", 32'(resp_id), 32'(k % NREQ));
      check_eq("rr_valid", 32'(resp_valid), 32'd1);
    end
    req_valid = '0;
    cycle();

    // Backpressure with requesters 1 and 2 waiting.
    do_reset();
    req_valid = 4'b0001;
    cycle();
    req_valid  = 4'b0110;
    resp_ready = 1'b0;
    held_y     = resp_y;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check_eq("bp_ready", 32'(req_ready), 32'd0);
      check_eq("bp_y", 32'(resp_y), 32'(held_y));
      check_eq("bp_id", 32'(resp_id), 32'd0);
    end
    resp_ready = 1'b1;
    #1;
    check_eq("bp_release", 32'(req_ready), 32'b0010);
    cycle();
    check_eq("bp_next_id", 32'(resp_id), 32'd1);

    // Reset while a response is pending, then only requester 3.
    rst       = 1'b1;
    req_valid = 4'b0100;
    cycle();
    rst       = 1'b0;
    req_valid = 4'b0000;
    #1;
    check_eq("mid_rst_valid", 32'(resp_valid), 32'd0);
    check_eq("mid_rst_y", 32'(resp_y), 32'd0);
    check_eq("mid_rst_id", 32'(resp_id), 32'd0);
    req_valid = 4'b1000;
    #1;
    check_eq("post_rst_ready", 32'(req_ready), 32'b1000);
    cycle();
    check_eq("post_rst_id", 32'(resp_id), 32'd3);
    req_valid = 4'b1010;
    #1;
    check_eq("post_rst_wrap", 32'(req_ready), 32'b0010);
    cycle();

`ifdef LU_ARBITER_PERF_EN
    do_reset();
    req_valid = 4'b0100;
    for (int k = 0; k < 10; k++) cycle();
    req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) cycle();
    req_valid = '0;
    perf_sel  = 2'd2;
    #1;
    check_eq("perf_2", 32'(perf_cnt), 32'd10);
    perf_sel = 2'd0;
    #1;
    check_eq("perf_0", 32'(perf_cnt), 32'd3);
    do_reset();
    #1;
    check_eq("perf_0_rst", 32'(perf_cnt), 32'd0);
    perf_sel = 2'd2;
    #1;
    check_eq("perf_2_rst", 32'(perf_cnt), 32'd0);
    @(negedge clk);
`endif

    // Random traffic: valids mostly held, occasional withdrawal and reset.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) req_valid = 4'($urandom);
      req_a      = {$urandom, $urandom};
      req_b      = {$urandom, $urandom};
      req_op     = 8'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
`ifdef LU_ARBITER_PERF_EN
      perf_sel   = 2'($urandom);
`endif
      cycle();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
